// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Combinational definitions only; no latency or backpressure of its own.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam int XLEN_DEF       = 32;
    localparam int AW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 4;

    // read, write, usign, misalgn, size[1:0] plus addr, wdata, wmask
    function automatic int cmd_w(input int aw, input int xlen);
        return aw + xlen + xlen / 8 + 6;
    endfunction

    localparam int CMD_W = AW_DEF + XLEN_DEF + XLEN_DEF / 8 + 6;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection: port 0 fixed priority, port 1 forced once port 0 has starved it.
// Purely combinational, zero latency; no backpressure of its own.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       p0_valid,
    input  logic       p1_valid,
    input  logic [3:0] starve_cnt,
    output logic [1:0] gnt
);

    logic starved;

    assign starved = (starve_cnt == 4'(STARVE_MAX));
    assign gnt[1]  = p1_valid && (!p0_valid || starved);
    assign gnt[0]  = p0_valid && !gnt[1];

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter/sequencer in front of mem_top; one op in flight, 3-cycle minimum period.
// Ready only in IDLE; the command is held on the mem bus until mem_i_ready, then a 1-cycle response pulse.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int AW         = AW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
`ifdef TEST_MODE
    output arb_state_e            test_state_o,
    output logic [3:0]            test_starve_o,
`endif
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_read,
    input  logic                  p0_req_write,
    input  logic                  p0_req_usign,
    input  logic                  p0_req_misalgn,
    input  logic [1:0]            p0_req_size,
    input  logic [AW-1:0]         p0_req_addr,
    input  logic [XLEN-1:0]       p0_req_wdata,
    input  logic [XLEN/8-1:0]     p0_req_wmask,
    output logic                  p0_rsp_valid,
    output logic [XLEN-1:0]       p0_rsp_rdata,
    output logic                  p0_rsp_err,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_read,
    input  logic                  p1_req_write,
    input  logic                  p1_req_usign,
    input  logic                  p1_req_misalgn,
    input  logic [1:0]            p1_req_size,
    input  logic [AW-1:0]         p1_req_addr,
    input  logic [XLEN-1:0]       p1_req_wdata,
    input  logic [XLEN/8-1:0]     p1_req_wmask,
    output logic                  p1_rsp_valid,
    output logic [XLEN-1:0]       p1_rsp_rdata,
    output logic                  p1_rsp_err,

    output logic                  mem_o_cmd_enable,
    output logic                  mem_o_cmd_read,
    output logic                  mem_o_cmd_write,
    output logic                  mem_o_cmd_usign,
    output logic                  mem_o_cmd_misalgn,
    output logic [1:0]            mem_o_cmd_size,
    output logic [AW-1:0]         mem_o_cmd_addr,
    output logic [XLEN-1:0]       mem_o_cmd_wdata,
    output logic [XLEN/8-1:0]     mem_o_cmd_wmask,
    input  logic [XLEN-1:0]       mem_i_rdata,
    input  logic                  mem_i_err,
    input  logic                  mem_i_ready
);

    localparam int CW = cmd_w(AW, XLEN);

    arb_state_e    state_q;
    logic          owner_q;
    logic [3:0]    starve_q;
    logic          cmd_en_q;
    logic [CW-1:0] cmd_q;
    logic [CW-1:0] cmd_d;
    logic [1:0]    pick_gnt;
    logic [1:0]    gnt;

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .p0_valid   (p0_req_valid),
        .p1_valid   (p1_req_valid),
        .starve_cnt (starve_q),
        .gnt        (pick_gnt)
    );

    assign gnt          = (state_q == ARB_IDLE) ? pick_gnt : 2'b00;
    assign p0_req_ready = gnt[0];
    assign p1_req_ready = gnt[1];

    assign cmd_d = gnt[1]
        ? {p1_req_read, p1_req_write, p1_req_usign, p1_req_misalgn, p1_req_size,
           p1_req_addr, p1_req_wdata, p1_req_wmask}
        : {p0_req_read, p0_req_write, p0_req_usign, p0_req_misalgn, p0_req_size,
           p0_req_addr, p0_req_wdata, p0_req_wmask};

    assign mem_o_cmd_enable = cmd_en_q;
    assign {mem_o_cmd_read, mem_o_cmd_write, mem_o_cmd_usign, mem_o_cmd_misalgn,
            mem_o_cmd_size, mem_o_cmd_addr, mem_o_cmd_wdata, mem_o_cmd_wmask} = cmd_q;

`ifdef TEST_MODE
    assign test_state_o  = state_q;
    assign test_starve_o = starve_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= 1'b0;
            starve_q     <= 4'd0;
            cmd_en_q     <= 1'b0;
            cmd_q        <= '0;
            p0_rsp_valid <= 1'b0;
            p0_rsp_rdata <= '0;
            p0_rsp_err   <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_rdata <= '0;
            p1_rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (!p1_req_valid) starve_q <= 4'd0;
                    if (gnt != 2'b00) begin
                        cmd_q    <= cmd_d;
                        owner_q  <= gnt[1];
                        cmd_en_q <= 1'b1;
                        state_q  <= ARB_BUSY;
                        // Count only port-0 wins that actually made port 1 wait
                        if (gnt[1])
                            starve_q <= 4'd0;
                        else if (p1_req_valid && starve_q != 4'(STARVE_MAX))
                            starve_q <= starve_q + 4'd1;
                    end
                end
                ARB_BUSY: begin
                    if (mem_i_ready) begin
                        cmd_en_q <= 1'b0;
                        state_q  <= ARB_RESP;
                        if (owner_q) begin
                            p1_rsp_valid <= 1'b1;
                            p1_rsp_rdata <= mem_i_rdata;
                            p1_rsp_err   <= mem_i_err;
                        end else begin
                            p0_rsp_valid <= 1'b1;
                            p0_rsp_rdata <= mem_i_rdata;
                            p0_rsp_err   <= mem_i_err;
                        end
                    end
                end
                ARB_RESP: begin
                    p0_rsp_valid <= 1'b0;
                    p1_rsp_valid <= 1'b0;
                    state_q      <= ARB_IDLE;
                end
                default: begin
                    cmd_en_q <= 1'b0;
                    state_q  <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: reset, single load, contention, starvation, error and mid-op reset.
module tb_mem_arb;
    localparam int XLEN = 32;
    localparam int AW   = 32;

    logic clk = 1'b0;
    logic rst_n;

    logic p0_req_valid, p0_req_ready, p0_req_read, p0_req_write, p0_req_usign, p0_req_misalgn;
    logic [1:0] p0_req_size;
    logic [AW-1:0] p0_req_addr;
    logic [XLEN-1:0] p0_req_wdata, p0_rsp_rdata;
    logic [XLEN/8-1:0] p0_req_wmask;
    logic p0_rsp_valid, p0_rsp_err;

    logic p1_req_valid, p1_req_ready, p1_req_read, p1_req_write, p1_req_usign, p1_req_misalgn;
    logic [1:0] p1_req_size;
    logic [AW-1:0] p1_req_addr;
    logic [XLEN-1:0] p1_req_wdata, p1_rsp_rdata;
    logic [XLEN/8-1:0] p1_req_wmask;
    logic p1_rsp_valid, p1_rsp_err;

    logic mem_o_cmd_enable, mem_o_cmd_read, mem_o_cmd_write, mem_o_cmd_usign, mem_o_cmd_misalgn;
    logic [1:0] mem_o_cmd_size;
    logic [AW-1:0] mem_o_cmd_addr;
    logic [XLEN-1:0] mem_o_cmd_wdata, mem_i_rdata;
    logic [XLEN/8-1:0] mem_o_cmd_wmask;
    logic mem_i_err, mem_i_ready;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arb #(.XLEN(XLEN), .AW(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_read(p0_req_read),
        .p0_req_write(p0_req_write), .p0_req_usign(p0_req_usign), .p0_req_misalgn(p0_req_misalgn),
        .p0_req_size(p0_req_size), .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_req_wmask(p0_req_wmask), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_read(p1_req_read),
        .p1_req_write(p1_req_write), .p1_req_usign(p1_req_usign), .p1_req_misalgn(p1_req_misalgn),
        .p1_req_size(p1_req_size), .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_req_wmask(p1_req_wmask), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .p1_rsp_err(p1_rsp_err),
        .mem_o_cmd_enable(mem_o_cmd_enable), .mem_o_cmd_read(mem_o_cmd_read),
        .mem_o_cmd_write(mem_o_cmd_write), .mem_o_cmd_usign(mem_o_cmd_usign),
        .mem_o_cmd_misalgn(mem_o_cmd_misalgn), .mem_o_cmd_size(mem_o_cmd_size),
        .mem_o_cmd_addr(mem_o_cmd_addr), .mem_o_cmd_wdata(mem_o_cmd_wdata),
        .mem_o_cmd_wmask(mem_o_cmd_wmask), .mem_i_rdata(mem_i_rdata),
        .mem_i_err(mem_i_err), .mem_i_ready(mem_i_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] order;

    initial begin
        rst_n = 1'b0;
        {p0_req_valid, p0_req_read, p0_req_write, p0_req_usign, p0_req_misalgn} = '0;
        {p1_req_valid, p1_req_read, p1_req_write, p1_req_usign, p1_req_misalgn} = '0;
        p0_req_size = '0; p0_req_addr = '0; p0_req_wdata = '0; p0_req_wmask = '0;
        p1_req_size = '0; p1_req_addr = '0; p1_req_wdata = '0; p1_req_wmask = '0;
        mem_i_rdata = '0; mem_i_err = 1'b0; mem_i_ready = 1'b0;

        // Reset state
        step(); step();
        chk("rst_enable", 64'(mem_o_cmd_enable), 64'd0);
        chk("rst_p0_ready", 64'(p0_req_ready), 64'd0);
        chk("rst_rsp_valid", 64'({p0_rsp_valid, p1_rsp_valid}), 64'd0);
        chk("rst_rdata", 64'(p0_rsp_rdata), 64'd0);
        chk("rst_cmd_addr", 64'(mem_o_cmd_addr), 64'd0);
        rst_n = 1'b1;
        step();

        // Single port-0 load, mem_i_ready on second BUSY cycle
        p0_req_valid = 1'b1; p0_req_read = 1'b1; p0_req_size = 2'd2; p0_req_addr = 32'h10;
        #1;
        chk("ld_p0_ready", 64'(p0_req_ready), 64'd1);
        chk("ld_p1_ready", 64'(p1_req_ready), 64'd0);
        step();
        p0_req_valid = 1'b0; p0_req_read = 1'b0; p0_req_addr = 32'h0;
        chk("ld_busy_en", 64'(mem_o_cmd_enable), 64'd1);
        chk("ld_busy_addr", 64'(mem_o_cmd_addr), 64'h10);
        chk("ld_busy_rd_sz", 64'({mem_o_cmd_read, mem_o_cmd_write, mem_o_cmd_size}), 64'b1010);
        step();
        mem_i_ready = 1'b1; mem_i_rdata = 32'hDEADBEEF;
        chk("ld_busy2_addr", 64'(mem_o_cmd_addr), 64'h10);
        chk("ld_busy2_novld", 64'(p0_rsp_valid), 64'd0);
        step();
        mem_i_ready = 1'b0; mem_i_rdata = 32'h0;
        chk("ld_rsp_vld", 64'({p0_rsp_valid, p1_rsp_valid}), 64'b10);
        chk("ld_rsp_rdata", 64'(p0_rsp_rdata), 64'hDEADBEEF);
        chk("ld_rsp_en_off", 64'(mem_o_cmd_enable), 64'd0);
        chk("ld_rsp_noready", 64'(p0_req_ready), 64'd0);
        step();
        chk("ld_idle_pulse", 64'(p0_rsp_valid), 64'd0);
        chk("ld_idle_hold", 64'(p0_rsp_rdata), 64'hDEADBEEF);

        // Simultaneous writes: port 0 first, port 1 on next IDLE
        p0_req_valid = 1'b1; p0_req_write = 1'b1; p0_req_addr = 32'h20; p0_req_wdata = 32'h1111; p0_req_wmask = 4'hF;
        p1_req_valid = 1'b1; p1_req_write = 1'b1; p1_req_addr = 32'h24; p1_req_wdata = 32'h2222; p1_req_wmask = 4'h3;
        #1;
        chk("sim_gnt", 64'({p1_req_ready, p0_req_ready}), 64'b01);
        step();
        p0_req_valid = 1'b0; p0_req_addr = 32'h0;
        chk("sim_b0_addr", 64'(mem_o_cmd_addr), 64'h20);
        chk("sim_b0_wdata", 64'({mem_o_cmd_write, mem_o_cmd_wmask, mem_o_cmd_wdata}), {27'd0, 1'b1, 4'hF, 32'h1111});
        step();
        chk("sim_b0_addr2", 64'(mem_o_cmd_addr), 64'h20);
        chk("sim_b0_p1wait", 64'(p1_req_ready), 64'd0);
        mem_i_ready = 1'b1; mem_i_err = 1'b0;
        step();
        mem_i_ready = 1'b0;
        chk("sim_r0_vld", 64'({p1_rsp_valid, p0_rsp_valid}), 64'b01);
        chk("sim_r0_p1wait", 64'(p1_req_ready), 64'd0);
        step();
        chk("sim_i1_gnt", 64'({p1_req_ready, p0_req_ready}), 64'b10);
        step();
        p1_req_valid = 1'b0; p1_req_addr = 32'h0;
        chk("sim_b1_addr", 64'(mem_o_cmd_addr), 64'h24);
        chk("sim_b1_wmask", 64'(mem_o_cmd_wmask), 64'h3);
        mem_i_ready = 1'b1;
        step();
        mem_i_ready = 1'b0;
        chk("sim_r1_vld", 64'({p1_rsp_valid, p0_rsp_valid}), 64'b10);
        step();

        // Starvation: grant order 0,0,0,0,1,0,0,0,0,1
        order = 10'b10000_10000;
        p0_req_valid = 1'b1; p1_req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("starve_gnt%0d", k), 64'({p1_req_ready, p0_req_ready}),
                order[k] ? 64'b10 : 64'b01);
            step();
            mem_i_ready = 1'b1;
            step();
            mem_i_ready = 1'b0;
            chk($sformatf("starve_rsp%0d", k), 64'({p1_rsp_valid, p0_rsp_valid}),
                order[k] ? 64'b10 : 64'b01);
            step();
        end
        p0_req_valid = 1'b0; p1_req_valid = 1'b0;
        p0_req_write = 1'b0; p1_req_write = 1'b0;
        step();

        // Error path: misaligned word read from port 1
        p1_req_valid = 1'b1; p1_req_read = 1'b1; p1_req_misalgn = 1'b1; p1_req_size = 2'd2; p1_req_addr = 32'h3;
        #1;
        chk("err_gnt", 64'({p1_req_ready, p0_req_ready}), 64'b10);
        step();
        p1_req_valid = 1'b0; p1_req_misalgn = 1'b0;
        chk("err_cmd", 64'({mem_o_cmd_misalgn, mem_o_cmd_addr}), {31'd0, 1'b1, 32'h3});
        mem_i_ready = 1'b1; mem_i_err = 1'b1; mem_i_rdata = 32'h0;
        step();
        mem_i_ready = 1'b0; mem_i_err = 1'b0;
        chk("err_rsp", 64'({p1_rsp_valid, p1_rsp_err, p0_rsp_valid}), 64'b110);
        step();
        chk("err_once", 64'(p1_rsp_valid), 64'd0);
        chk("err_hold", 64'(p1_rsp_err), 64'd1);

        // Reset while BUSY: command dropped, no response, next op normal
        p0_req_valid = 1'b1; p0_req_read = 1'b1; p0_req_addr = 32'h40;
        step();
        p0_req_valid = 1'b0;
        chk("mrst_busy", 64'(mem_o_cmd_enable), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_en_off", 64'(mem_o_cmd_enable), 64'd0);
        mem_i_ready = 1'b1; mem_i_rdata = 32'hBAD0BAD0;
        step();
        rst_n = 1'b1;
        step();
        chk("mrst_no_rsp", 64'({p1_rsp_valid, p0_rsp_valid, mem_o_cmd_enable}), 64'd0);
        mem_i_ready = 1'b0;
        step();
        chk("mrst_no_rsp2", 64'({p1_rsp_valid, p0_rsp_valid}), 64'd0);
        p1_req_valid = 1'b1; p1_req_addr = 32'h80; p1_req_read = 1'b1;
        #1;
        chk("mrst_gnt", 64'({p1_req_ready, p0_req_ready}), 64'b10);
        step();
        p1_req_valid = 1'b0;
        chk("mrst_cmd", 64'(mem_o_cmd_addr), 64'h80);
        mem_i_ready = 1'b1; mem_i_rdata = 32'h12345678;
        step();
        mem_i_ready = 1'b0;
        chk("mrst_rsp", 64'({p1_rsp_valid, p1_rsp_err, p0_rsp_valid}), 64'b100);
        chk("mrst_rdata", 64'(p1_rsp_rdata), 64'h12345678);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
